// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte sources.
// Define UART_ARB_LOCK_EN to keep a requester granted until its last byte.
module uart_tx_arb #(
  parameter int NUM_REQ   = 4,
  parameter int BUSY_WAIT = 15,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_dout_8b,
  output logic                 o_dout_valid,
  input  logic                 i_tx_busy,
  output logic [IW-1:0]        o_grant_id,
  output logic                 o_busy,
  output logic [15:0]          o_byte_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t             state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      win;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      cand;
  logic [7:0]         wait_cnt;
  logic [NUM_REQ-1:0] elig;
  logic               found;

`ifdef UART_ARB_LOCK_EN
  logic          lock;
  logic          win_last;
  logic [IW-1:0] lock_id;

  // A locked message masks every other requester.
  assign elig = lock ? (i_req_valid & (NUM_REQ'(1) << lock_id))
                     : i_req_valid;
`else
  logic unused_last;

  assign unused_last = ^i_req_last;
  assign elig        = i_req_valid;
`endif

  // Search starts just after the previous winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign o_grant_id = last_grant;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      o_req_ready  <= '0;
      o_dout_valid <= 1'b0;
      o_dout_8b    <= 8'h00;
      o_busy       <= 1'b0;
      o_byte_cnt   <= 16'h0000;
      wait_cnt     <= 8'h00;
      win          <= '0;
      last_grant   <= IW'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock         <= 1'b0;
      lock_id      <= '0;
      win_last     <= 1'b0;
`endif
    end else begin
      o_req_ready  <= '0;
      o_dout_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found && !i_tx_busy) begin
            win          <= pick;
            o_dout_8b    <= i_req_data[{pick, 3'b000} +: 8];
            o_dout_valid <= 1'b1;
            o_req_ready  <= NUM_REQ'(1) << pick;
            o_byte_cnt   <= o_byte_cnt + 16'd1;
            o_busy       <= 1'b1;
            state        <= ISSUE;
`ifdef UART_ARB_LOCK_EN
            win_last     <= i_req_last[pick];
`endif
          end
        end
        ISSUE: begin
          wait_cnt <= 8'h00;
          state    <= WAIT_BUSY;
`ifdef UART_ARB_LOCK_EN
          lock     <= !win_last;
          lock_id  <= win;
`endif
        end
        WAIT_BUSY: begin
          // Give up on a busy pulse that never shows up.
          if (i_tx_busy || wait_cnt == 8'(BUSY_WAIT - 1)) begin
            state <= WAIT_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            last_grant <= win;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed scoreboard bench for uart_tx_arb.
// Expected issue order follows UART_ARB_LOCK_EN when defined.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int BW = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     dout;
  logic           dout_valid;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           busy;
  logic [15:0]    byte_cnt;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .NUM_REQ(N),
    .BUSY_WAIT(BW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .i_req_data(req_data),
    .i_req_last(req_last),
    .o_req_ready(req_ready),
    .o_dout_8b(dout),
    .o_dout_valid(dout_valid),
    .i_tx_busy(tx_busy),
    .o_grant_id(grant_id),
    .o_busy(busy),
    .o_byte_cnt(byte_cnt)
  );

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  src[N][16];
  int          src_n[N];
  int          src_p[N];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;
  int          tx_mode = 0;
  int          busy_len = 3;
  int          busy_cnt = 0;
  logic        saw_valid = 1'b0;
  logic [N-1:0] saw_ready = '0;
  int          last_issue = -1;
  int          prev_issue = -1;
  logic [15:0] exp_cnt = 16'h0;
  int          t0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic add_src(input int k, input logic last,
                         input logic [7:0] d);
    src[k][src_n[k]] = {last, d};
    src_n[k]++;
  endtask

  task automatic expect_b(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_p[k] < src_n[k]) begin
        req_valid[k]        = 1'b1;
        req_data[8*k +: 8]  = src[k][src_p[k]][7:0];
        req_last[k]         = src[k][src_p[k]][8];
      end else begin
        req_valid[k]        = 1'b0;
        req_data[8*k +: 8]  = 8'h00;
        req_last[k]         = 1'b0;
      end
    end
  endtask

  // One clock: update requesters and transmitter, then monitor.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    cyc_no++;
    #1;
    for (int k = 0; k < N; k++)
      if (saw_ready[k]) src_p[k]++;
    drive();
    if (tx_mode == 2) begin
      tx_busy = 1'b1;
    end else if (tx_mode == 1) begin
      if (saw_valid) busy_cnt = busy_len;
      if (busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy = 1'b0;
      end
    end else begin
      tx_busy = 1'b0;
    end
    @(negedge clk);
    saw_valid = dout_valid;
    saw_ready = req_ready;
    if (dout_valid) begin
      chk("issue_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_cnt++;
        chk("issue_data", dout, e.d);
        chk("issue_ready", req_ready, 1 << e.id);
        chk("issue_cnt", byte_cnt, exp_cnt);
        prev_issue = last_issue;
        last_issue = cyc_no;
      end
    end else if (req_ready !== '0) begin
      chk("ready_without_valid", req_ready, 0);
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      cyc();
      if (exp_q.size() == 0 && !busy) done = 1;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      src_n[k] = 0;
      src_p[k] = 0;
    end
    exp_q.delete();
    exp_cnt   = 16'h0;
    busy_cnt  = 0;
    saw_valid = 1'b0;
    saw_ready = '0;
    drive();
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    tx_busy   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    do_reset();
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", byte_cnt, 0);
    chk("rst_grant", grant_id, N - 1);

    // Single byte from requester 2, one-cycle issue latency.
    tx_mode  = 1;
    busy_len = 3;
    add_src(2, 1'b1, 8'h41);
    expect_b(2, 8'h41);
    t0 = cyc_no;
    drain();
    chk("single_latency", last_issue, t0 + 2);
    chk("single_cnt", byte_cnt, 1);
    chk("single_grant", grant_id, 2);

    // Four requesters always valid: plain rotation.
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < N; k++) begin
        add_src(k, 1'b1, 8'(16 * k + j + 1));
        expect_b(k, 8'(16 * k + j + 1));
      end
    drain();
    chk("rr_cnt", byte_cnt, 8);
    chk("rr_grant", grant_id, 3);

    // Transmitter never raises busy: timeout sets issue spacing.
    tx_mode = 0;
    add_src(3, 1'b0, 8'hA1);
    add_src(3, 1'b1, 8'hA2);
    expect_b(3, 8'hA1);
    expect_b(3, 8'hA2);
    drain();
    chk("busy_wait_gap", last_issue - prev_issue, BW + 3);

    // Transmitter held busy: nothing granted.
    tx_mode = 2;
    add_src(0, 1'b1, 8'hB0);
    add_src(2, 1'b1, 8'hB2);
    repeat (100) cyc();
    chk("held_busy_idle", busy, 0);
    chk("held_busy_cnt", byte_cnt, exp_cnt);
    expect_b(0, 8'hB0);
    expect_b(2, 8'hB2);
    tx_mode = 1;
    drain();
    chk("held_busy_grant", grant_id, 2);

    // Multi-byte message from requester 1 against requester 0.
    add_src(1, 1'b0, 8'hC1);
    add_src(1, 1'b0, 8'hC2);
    add_src(1, 1'b1, 8'hC3);
    cyc();
    add_src(0, 1'b1, 8'hD1);
    add_src(0, 1'b1, 8'hD2);
`ifdef UART_ARB_LOCK_EN
    expect_b(1, 8'hC1);
    expect_b(1, 8'hC2);
    expect_b(1, 8'hC3);
    expect_b(0, 8'hD1);
    expect_b(0, 8'hD2);
`else
    expect_b(1, 8'hC1);
    expect_b(0, 8'hD1);
    expect_b(1, 8'hC2);
    expect_b(0, 8'hD2);
    expect_b(1, 8'hC3);
`endif
    drain();

    // Reset while waiting for the transmitter to finish.
    busy_len = 10;
    add_src(1, 1'b1, 8'h5A);
    expect_b(1, 8'h5A);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc();
    chk("mid_issued", 32'(exp_q.size()), 0);
    repeat (4) cyc();
    chk("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", byte_cnt, 0);
    chk("mid_rst_grant", grant_id, N - 1);
    #1 rst = 1'b0;
    exp_cnt  = 16'h0;
    tx_mode  = 0;
    busy_cnt = 0;
    repeat (30) cyc();
    chk("no_reissue_cnt", byte_cnt, 0);
    chk("no_reissue_busy", busy, 0);

    // Counter wrap.
    force dut.o_byte_cnt = 16'hFFFF;
    cyc();
    release dut.o_byte_cnt;
    cyc();
    chk("preload_cnt", byte_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    tx_mode = 1;
    busy_len = 3;
    add_src(3, 1'b1, 8'hE7);
    expect_b(3, 8'hE7);
    drain();
    chk("cnt_wrap", byte_cnt, 0);
    chk("wrap_grant", grant_id, 3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
